// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit common-anode seven-segment driver.
// Snapshots the packed BCD/separator word once per frame, with per-digit blanking and blinking.
module seg_scan_driver #(
    parameter int unsigned DIGIT_CYC = 50_000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned BLINK_CYC = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int unsigned SLOT_W  = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
    localparam int unsigned BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYC - 1);
    localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    logic [SLOT_W-1:0]  r_slot;
    logic [2:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [31:0]        r_shadow;
    logic [7:0]         r_sel;
    logic [7:0]         r_seg;
    logic               r_frame_start;

    logic               w_slot_wrap;
    logic               w_blink_wrap;
    logic               w_frame_load;
    logic [3:0]         w_nibble;
    logic [7:0]         w_seg_on;
    logic [7:0]         w_sel_next;
    logic [7:0]         w_seg_next;

    assign w_slot_wrap  = (r_slot == SLOT_LAST);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    assign w_frame_load = (r_idx == 3'd0) && (r_slot == '0);
    assign w_nibble     = r_shadow[{r_idx, 2'b00} +: 4];

    // Slot timer and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_idx  <= 3'd0;
        end else if (w_slot_wrap) begin
            r_slot <= '0;
            r_idx  <= r_idx + 3'd1;
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    // Blink half-period timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Frame snapshot lands in digit 0's blank window, so no frame mixes old and new data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow      <= 32'hFFFF_FFFF;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_load;
            if (w_frame_load) begin
                r_shadow <= din;
            end
        end
    end

    // Code to active-high {dp,g,f,e,d,c,b,a}; dp never lit
    always_comb begin
        w_seg_on = 8'h00;
        case (w_nibble)
            4'h0: w_seg_on = 8'h3F;
            4'h1: w_seg_on = 8'h06;
            4'h2: w_seg_on = 8'h5B;
            4'h3: w_seg_on = 8'h4F;
            4'h4: w_seg_on = 8'h66;
            4'h5: w_seg_on = 8'h6D;
            4'h6: w_seg_on = 8'h7D;
            4'h7: w_seg_on = 8'h07;
            4'h8: w_seg_on = 8'h7F;
            4'h9: w_seg_on = 8'h6F;
            4'hA: w_seg_on = 8'h40;
            4'hB: w_seg_on = 8'h7C;
            4'hC: w_seg_on = 8'h39;
            4'hD: w_seg_on = 8'h5E;
            4'hE: w_seg_on = 8'h79;
            default: w_seg_on = 8'h00;
        endcase
    end

    always_comb begin
        w_sel_next = 8'hFF;
        w_seg_next = ~w_seg_on;
        if ((r_slot >= SLOT_BLANK) && !blank_mask[r_idx]) begin
            w_sel_next = ~(8'b1 << r_idx);
        end
        if (blink_mask[r_idx] && r_blink_phase) begin
            w_seg_next = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_sel <= w_sel_next;
            r_seg <= w_seg_next;
        end
    end

    assign sel         = r_sel;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGIT_CYC=8, BLANK_CYC=2, BLINK_CYC=64.
// Edge n after reset release shows the outputs computed from scan state n-1.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic        frame_start;

    int n_pass  = 0;
    int n_total = 0;
    int edges   = 0;

    typedef struct {
        string       name;
        logic        restart;
        logic [31:0] din;
        logic [7:0]  blank;
        logic [7:0]  blink;
        int          n;
        logic [7:0]  sel;
        logic [7:0]  seg;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    seg_scan_driver #(
        .DIGIT_CYC(8),
        .BLANK_CYC(2),
        .BLINK_CYC(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .sel        (sel),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic run_to(input int n);
        while (edges < n) step();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic check_out(input string name, input logic [7:0] s, input logic [7:0] g, input logic f);
        check({name, ".sel"}, sel, s);
        check({name, ".seg"}, seg, g);
        check({name, ".fs"}, {7'd0, frame_start}, {7'd0, f});
    endtask

    task automatic do_reset(input logic [31:0] d, input logic [7:0] bm, input logic [7:0] km);
        rst        = 1'b1;
        din        = d;
        blank_mask = bm;
        blink_mask = km;
        repeat (3) step();
        check_out("in_reset", 8'hFF, 8'hFF, 1'b0);
        rst   = 1'b0;
        edges = 0;
    endtask

    function automatic void add(input string nm, input logic rs, input logic [31:0] d,
                                input logic [7:0] bm, input logic [7:0] km, input int n,
                                input logic [7:0] s, input logic [7:0] g, input logic f);
        vecs.push_back('{nm, rs, d, bm, km, n, s, g, f});
    endfunction

    initial begin
        rst        = 1'b1;
        din        = 32'h0;
        blank_mask = 8'h0;
        blink_mask = 8'h0;

        // Scan and decode, frame_start cadence
        add("scan_load",   1, 32'h12A34A56, 8'h00, 8'h00,   1, 8'hFF, 8'hFF, 1);
        add("scan_d0_s1",  0, 32'h12A34A56, 8'h00, 8'h00,   2, 8'hFF, 8'h82, 0);
        add("scan_d0_s2",  0, 32'h12A34A56, 8'h00, 8'h00,   3, 8'hFE, 8'h82, 0);
        add("scan_d0_s7",  0, 32'h12A34A56, 8'h00, 8'h00,   8, 8'hFE, 8'h82, 0);
        add("scan_d1_s0",  0, 32'h12A34A56, 8'h00, 8'h00,   9, 8'hFF, 8'h92, 0);
        add("scan_d1_s2",  0, 32'h12A34A56, 8'h00, 8'h00,  11, 8'hFD, 8'h92, 0);
        add("scan_d2",     0, 32'h12A34A56, 8'h00, 8'h00,  19, 8'hFB, 8'hBF, 0);
        add("scan_d3",     0, 32'h12A34A56, 8'h00, 8'h00,  27, 8'hF7, 8'h99, 0);
        add("scan_d4",     0, 32'h12A34A56, 8'h00, 8'h00,  35, 8'hEF, 8'hB0, 0);
        add("scan_d5",     0, 32'h12A34A56, 8'h00, 8'h00,  43, 8'hDF, 8'hBF, 0);
        add("scan_d6",     0, 32'h12A34A56, 8'h00, 8'h00,  51, 8'hBF, 8'hA4, 0);
        add("scan_d7",     0, 32'h12A34A56, 8'h00, 8'h00,  59, 8'h7F, 8'hF9, 0);
        add("scan_d7_end", 0, 32'h12A34A56, 8'h00, 8'h00,  64, 8'h7F, 8'hF9, 0);
        add("scan_fs2",    0, 32'h12A34A56, 8'h00, 8'h00,  65, 8'hFF, 8'h82, 1);
        add("scan_fs2_p",  0, 32'h12A34A56, 8'h00, 8'h00,  66, 8'hFF, 8'h82, 0);
        add("scan_fs3",    0, 32'h12A34A56, 8'h00, 8'h00, 129, 8'hFF, 8'h82, 1);
        // Blanking of digit 7
        add("blank_d0",    1, 32'h12A34A56, 8'h80, 8'h00,   3, 8'hFE, 8'h82, 0);
        add("blank_d6",    0, 32'h12A34A56, 8'h80, 8'h00,  51, 8'hBF, 8'hA4, 0);
        add("blank_d7_s0", 0, 32'h12A34A56, 8'h80, 8'h00,  57, 8'hFF, 8'hF9, 0);
        add("blank_d7_s2", 0, 32'h12A34A56, 8'h80, 8'h00,  59, 8'hFF, 8'hF9, 0);
        add("blank_d7_s7", 0, 32'h12A34A56, 8'h80, 8'h00,  64, 8'hFF, 8'hF9, 0);
        add("blank_next",  0, 32'h12A34A56, 8'h80, 8'h00,  67, 8'hFE, 8'h82, 0);
        // Blinking of digits 0 and 1
        add("blink_p0_d0", 1, 32'h12A34A56, 8'h00, 8'h03,   3, 8'hFE, 8'h82, 0);
        add("blink_p0_d1", 0, 32'h12A34A56, 8'h00, 8'h03,  11, 8'hFD, 8'h92, 0);
        add("blink_p1_ld", 0, 32'h12A34A56, 8'h00, 8'h03,  65, 8'hFF, 8'hFF, 1);
        add("blink_p1_d0", 0, 32'h12A34A56, 8'h00, 8'h03,  67, 8'hFE, 8'hFF, 0);
        add("blink_p1_d1", 0, 32'h12A34A56, 8'h00, 8'h03,  75, 8'hFD, 8'hFF, 0);
        add("blink_p1_d2", 0, 32'h12A34A56, 8'h00, 8'h03,  83, 8'hFB, 8'hBF, 0);
        add("blink_p1_d7", 0, 32'h12A34A56, 8'h00, 8'h03, 123, 8'h7F, 8'hF9, 0);
        add("blink_p0_s1", 0, 32'h12A34A56, 8'h00, 8'h03, 130, 8'hFF, 8'h82, 0);
        add("blink_p0b",   0, 32'h12A34A56, 8'h00, 8'h03, 131, 8'hFE, 8'h82, 0);
        add("blink_p1b_0", 0, 32'h12A34A56, 8'h00, 8'h03, 195, 8'hFE, 8'hFF, 0);
        add("blink_p1b_1", 0, 32'h12A34A56, 8'h00, 8'h03, 203, 8'hFD, 8'hFF, 0);

        foreach (vecs[i]) begin
            if (vecs[i].restart) do_reset(vecs[i].din, vecs[i].blank, vecs[i].blink);
            run_to(vecs[i].n);
            check_out(vecs[i].name, vecs[i].sel, vecs[i].seg, vecs[i].fs);
        end

        // Frame snapshot: din change during digit 3 waits for the next frame
        do_reset(32'h12A34A56, 8'h00, 8'h00);
        run_to(28);
        din = 32'h0000_0000;
        run_to(35);  check_out("snap_d4_old", 8'hEF, 8'hB0, 1'b0);
        run_to(43);  check_out("snap_d5_old", 8'hDF, 8'hBF, 1'b0);
        run_to(59);  check_out("snap_d7_old", 8'h7F, 8'hF9, 1'b0);
        run_to(65);  check_out("snap_load",   8'hFF, 8'h82, 1'b1);
        run_to(67);  check_out("snap_d0_new", 8'hFE, 8'hC0, 1'b0);
        run_to(75);  check_out("snap_d1_new", 8'hFD, 8'hC0, 1'b0);
        run_to(123); check_out("snap_d7_new", 8'h7F, 8'hC0, 1'b0);

        // Mid-frame asynchronous reset while digit 5 is lit
        do_reset(32'h12A34A56, 8'h00, 8'h00);
        run_to(44);  check_out("mid_d5", 8'hDF, 8'hBF, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_out("mid_async", 8'hFF, 8'hFF, 1'b0);
        repeat (2) step();
        rst   = 1'b0;
        edges = 0;
        run_to(1);   check_out("mid_restart", 8'hFF, 8'hFF, 1'b1);
        run_to(2);   check_out("mid_blank",   8'hFF, 8'h82, 1'b0);
        run_to(3);   check_out("mid_d0",      8'hFE, 8'h82, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
